// File: rtl/axi_chan_buffer.sv
// AXI4 decoupling buffer: an independently sized FIFO (or plain wire when Depth=0) on each of
// AW/W/B/AR/R in one clock domain. Define AXI_CHAN_BUFFER_STATUS_EN for occupancy/overflow ports.

package axi_chan_buffer_pkg;
  typedef struct packed {
    logic aw;
    logic aw_valid;
    logic w;
    logic w_valid;
    logic b_ready;
    logic ar;
    logic ar_valid;
    logic r_ready;
  } dflt_req_t;

  typedef struct packed {
    logic aw_ready;
    logic w_ready;
    logic b;
    logic b_valid;
    logic ar_ready;
    logic r;
    logic r_valid;
  } dflt_resp_t;
endpackage

module axi_chan_buffer_fifo #(
  parameter type          data_t      = logic,
  parameter int unsigned  Depth       = 1,
  parameter bit           FallThrough = 1'b0,
  localparam int unsigned CntW        = $clog2(Depth + 1),
  localparam int unsigned PtrW        = (Depth > 1) ? $clog2(Depth) : 1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  data_t           in_data_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output data_t           out_data_o,
  output logic [CntW-1:0] count_o
);
  localparam logic [CntW-1:0] DepthC  = CntW'(Depth);
  localparam logic [PtrW-1:0] LastPtr = PtrW'(Depth - 1);

  data_t           mem_q [Depth];
  logic [PtrW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            empty, full, push, pop, wr_en, rd_en;

  assign empty      = (count_q == '0);
  assign full       = (count_q == DepthC);
  // Ready only looks at occupancy: a pop in the same cycle never frees a slot early.
  assign in_ready_o = !full;
  assign count_o    = count_q;

  always_comb begin
    if (FallThrough && empty) begin
      out_valid_o = in_valid_i;
      out_data_o  = in_data_i;
    end else begin
      out_valid_o = !empty;
      out_data_o  = mem_q[rptr_q];
    end
  end

  assign push  = in_valid_i & in_ready_o;
  assign pop   = out_valid_o & out_ready_i;
  // A fall-through beat consumed while empty never touches storage.
  assign wr_en = push & !(FallThrough && empty && pop);
  assign rd_en = pop & !empty;

  // NOTE: every signal gets its default before the conditionals so no latch is inferred.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (wr_en) wptr_d = (wptr_q == LastPtr) ? '0 : wptr_q + 1'b1;
    if (rd_en) rptr_d = (rptr_q == LastPtr) ? '0 : rptr_q + 1'b1;
    if (wr_en && !rd_en)      count_d = count_q + 1'b1;
    else if (rd_en && !wr_en) count_d = count_q - 1'b1;
  end

  // NOTE: state uses non-blocking assignments; storage is reset as well so nothing stale
  // survives a reset asserted mid-transaction.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < Depth; i++) mem_q[i] <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (wr_en) mem_q[wptr_q] <= in_data_i;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end
endmodule

module axi_chan_buffer #(
  parameter type          aw_chan_t   = logic,
  parameter type          w_chan_t    = logic,
  parameter type          b_chan_t    = logic,
  parameter type          ar_chan_t   = logic,
  parameter type          r_chan_t    = logic,
  parameter type          axi_req_t   = axi_chan_buffer_pkg::dflt_req_t,
  parameter type          axi_resp_t  = axi_chan_buffer_pkg::dflt_resp_t,
  parameter int unsigned  AwDepth     = 1,
  parameter int unsigned  WDepth      = 1,
  parameter int unsigned  BDepth      = 1,
  parameter int unsigned  ArDepth     = 1,
  parameter int unsigned  RDepth      = 1,
  parameter bit           FallThrough = 1'b0,
  localparam int unsigned AwCntW      = (AwDepth == 0) ? 1 : $clog2(AwDepth + 1),
  localparam int unsigned WCntW       = (WDepth == 0) ? 1 : $clog2(WDepth + 1),
  localparam int unsigned BCntW       = (BDepth == 0) ? 1 : $clog2(BDepth + 1),
  localparam int unsigned ArCntW      = (ArDepth == 0) ? 1 : $clog2(ArDepth + 1),
  localparam int unsigned RCntW       = (RDepth == 0) ? 1 : $clog2(RDepth + 1)
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  axi_req_t    slv_req_i,
  output axi_resp_t   slv_resp_o,
  output axi_req_t    mst_req_o,
  input  axi_resp_t   mst_resp_i,
  output logic        idle_o
`ifdef AXI_CHAN_BUFFER_STATUS_EN
  ,
  output logic [AwCntW-1:0] aw_cnt_o,
  output logic [WCntW-1:0]  w_cnt_o,
  output logic [BCntW-1:0]  b_cnt_o,
  output logic [ArCntW-1:0] ar_cnt_o,
  output logic [RCntW-1:0]  r_cnt_o,
  output logic              aw_overflow_attempt_o,
  output logic              w_overflow_attempt_o,
  output logic              b_overflow_attempt_o,
  output logic              ar_overflow_attempt_o,
  output logic              r_overflow_attempt_o
`endif
);
  logic aw_in_ready, aw_out_valid, w_in_ready, w_out_valid, b_in_ready, b_out_valid;
  logic ar_in_ready, ar_out_valid, r_in_ready, r_out_valid;
  aw_chan_t aw_out_data;
  w_chan_t  w_out_data;
  b_chan_t  b_out_data;
  ar_chan_t ar_out_data;
  r_chan_t  r_out_data;
  logic [AwCntW-1:0] aw_cnt;
  logic [WCntW-1:0]  w_cnt;
  logic [BCntW-1:0]  b_cnt;
  logic [ArCntW-1:0] ar_cnt;
  logic [RCntW-1:0]  r_cnt;

  if (AwDepth == 0) begin : g_aw_wire
    assign aw_in_ready  = mst_resp_i.aw_ready;
    assign aw_out_valid = slv_req_i.aw_valid;
    assign aw_out_data  = slv_req_i.aw;
    assign aw_cnt       = '0;
  end else begin : g_aw_fifo
    axi_chan_buffer_fifo #(.data_t(aw_chan_t), .Depth(AwDepth), .FallThrough(FallThrough)) i_fifo (
      .clk_i, .rst_ni,
      .in_valid_i (slv_req_i.aw_valid), .in_ready_o (aw_in_ready),  .in_data_i  (slv_req_i.aw),
      .out_valid_o(aw_out_valid),       .out_ready_i(mst_resp_i.aw_ready), .out_data_o(aw_out_data),
      .count_o    (aw_cnt)
    );
  end

  if (WDepth == 0) begin : g_w_wire
    assign w_in_ready  = mst_resp_i.w_ready;
    assign w_out_valid = slv_req_i.w_valid;
    assign w_out_data  = slv_req_i.w;
    assign w_cnt       = '0;
  end else begin : g_w_fifo
    axi_chan_buffer_fifo #(.data_t(w_chan_t), .Depth(WDepth), .FallThrough(FallThrough)) i_fifo (
      .clk_i, .rst_ni,
      .in_valid_i (slv_req_i.w_valid), .in_ready_o (w_in_ready),  .in_data_i  (slv_req_i.w),
      .out_valid_o(w_out_valid),       .out_ready_i(mst_resp_i.w_ready), .out_data_o(w_out_data),
      .count_o    (w_cnt)
    );
  end

  if (BDepth == 0) begin : g_b_wire
    assign b_in_ready  = slv_req_i.b_ready;
    assign b_out_valid = mst_resp_i.b_valid;
    assign b_out_data  = mst_resp_i.b;
    assign b_cnt       = '0;
  end else begin : g_b_fifo
    axi_chan_buffer_fifo #(.data_t(b_chan_t), .Depth(BDepth), .FallThrough(FallThrough)) i_fifo (
      .clk_i, .rst_ni,
      .in_valid_i (mst_resp_i.b_valid), .in_ready_o (b_in_ready),  .in_data_i  (mst_resp_i.b),
      .out_valid_o(b_out_valid),        .out_ready_i(slv_req_i.b_ready), .out_data_o(b_out_data),
      .count_o    (b_cnt)
    );
  end

  if (ArDepth == 0) begin : g_ar_wire
    assign ar_in_ready  = mst_resp_i.ar_ready;
    assign ar_out_valid = slv_req_i.ar_valid;
    assign ar_out_data  = slv_req_i.ar;
    assign ar_cnt       = '0;
  end else begin : g_ar_fifo
    axi_chan_buffer_fifo #(.data_t(ar_chan_t), .Depth(ArDepth), .FallThrough(FallThrough)) i_fifo (
      .clk_i, .rst_ni,
      .in_valid_i (slv_req_i.ar_valid), .in_ready_o (ar_in_ready),  .in_data_i  (slv_req_i.ar),
      .out_valid_o(ar_out_valid),       .out_ready_i(mst_resp_i.ar_ready), .out_data_o(ar_out_data),
      .count_o    (ar_cnt)
    );
  end

  if (RDepth == 0) begin : g_r_wire
    assign r_in_ready  = slv_req_i.r_ready;
    assign r_out_valid = mst_resp_i.r_valid;
    assign r_out_data  = mst_resp_i.r;
    assign r_cnt       = '0;
  end else begin : g_r_fifo
    axi_chan_buffer_fifo #(.data_t(r_chan_t), .Depth(RDepth), .FallThrough(FallThrough)) i_fifo (
      .clk_i, .rst_ni,
      .in_valid_i (mst_resp_i.r_valid), .in_ready_o (r_in_ready),  .in_data_i  (mst_resp_i.r),
      .out_valid_o(r_out_valid),        .out_ready_i(slv_req_i.r_ready), .out_data_o(r_out_data),
      .count_o    (r_cnt)
    );
  end

  // Unlisted struct fields pass straight through; channel fields are overridden below.
  always_comb begin
    mst_req_o          = slv_req_i;
    mst_req_o.aw       = aw_out_data;
    mst_req_o.aw_valid = aw_out_valid;
    mst_req_o.w        = w_out_data;
    mst_req_o.w_valid  = w_out_valid;
    mst_req_o.ar       = ar_out_data;
    mst_req_o.ar_valid = ar_out_valid;
    mst_req_o.b_ready  = b_in_ready;
    mst_req_o.r_ready  = r_in_ready;

    slv_resp_o          = mst_resp_i;
    slv_resp_o.aw_ready = aw_in_ready;
    slv_resp_o.w_ready  = w_in_ready;
    slv_resp_o.ar_ready = ar_in_ready;
    slv_resp_o.b        = b_out_data;
    slv_resp_o.b_valid  = b_out_valid;
    slv_resp_o.r        = r_out_data;
    slv_resp_o.r_valid  = r_out_valid;
  end

  assign idle_o = (aw_cnt == '0) && (w_cnt == '0) && (b_cnt == '0) &&
                  (ar_cnt == '0) && (r_cnt == '0);

`ifdef AXI_CHAN_BUFFER_STATUS_EN
  logic [4:0] ovf_q, ovf_set;

  // A buffered channel is full exactly when its ready is low; wires never overflow.
  assign ovf_set = {(AwDepth != 0) && slv_req_i.aw_valid  && !aw_in_ready,
                    (WDepth  != 0) && slv_req_i.w_valid   && !w_in_ready,
                    (BDepth  != 0) && mst_resp_i.b_valid  && !b_in_ready,
                    (ArDepth != 0) && slv_req_i.ar_valid  && !ar_in_ready,
                    (RDepth  != 0) && mst_resp_i.r_valid  && !r_in_ready};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) ovf_q <= '0;
    else         ovf_q <= ovf_q | ovf_set;
  end

  assign aw_cnt_o = aw_cnt;
  assign w_cnt_o  = w_cnt;
  assign b_cnt_o  = b_cnt;
  assign ar_cnt_o = ar_cnt;
  assign r_cnt_o  = r_cnt;
  assign {aw_overflow_attempt_o, w_overflow_attempt_o, b_overflow_attempt_o,
          ar_overflow_attempt_o, r_overflow_attempt_o} = ovf_q;
`endif
endmodule
